// File: rtl/seed_random_2_deal_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seed_random_2_deal_ctrl_pkg
// Shared definitions for the card-deal controller: default latency and deck
// size, FSM state encoding, requester ownership encoding and a small helper
// that classifies a datapath card value.
// -----------------------------------------------------------------------------
package seed_random_2_deal_ctrl_pkg;

    // Cycles from req_card_dp_o to a valid card on card_dp_i.
    localparam int CARD_LAT_DEF  = 2;
    // Cards that may be dealt before the deck counts as exhausted.
    localparam int DECK_SIZE_DEF = 52;
    localparam int CARD_W        = 8;
    localparam int DEALT_W       = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } deal_state_e;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // A card value of 0 means the datapath produced nothing usable.
    function automatic logic is_bad_card(input logic [CARD_W-1:0] card);
        return (card == 8'd0);
    endfunction

endpackage

// File: rtl/seed_random_2_deal_ctrl_if.sv
// -----------------------------------------------------------------------------
// seed_random_2_deal_ctrl_if
// Bundles the requester handshakes, the datapath card handshake and the
// status outputs of the deal controller.
//   master : player/dealer requesters + card datapath (drives requests, card)
//   slave  : the deal controller (drives acks, card, counters, flags)
// -----------------------------------------------------------------------------
interface seed_random_2_deal_ctrl_if;
    import seed_random_2_deal_ctrl_pkg::*;

    logic               req_p_i;
    logic               req_d_i;
    logic               new_deck_i;
    logic [CARD_W-1:0]  card_dp_i;
    logic               req_card_dp_o;
    logic               ack_p_o;
    logic               ack_d_o;
    logic [CARD_W-1:0]  card_o;
    logic [DEALT_W-1:0] cards_dealt_o;
    logic               deck_empty_o;
    logic               busy_o;
    logic               bad_card_o;

    modport master (
        output req_p_i, req_d_i, new_deck_i, card_dp_i,
        input  req_card_dp_o, ack_p_o, ack_d_o, card_o, cards_dealt_o,
               deck_empty_o, busy_o, bad_card_o
    );

    modport slave (
        input  req_p_i, req_d_i, new_deck_i, card_dp_i,
        output req_card_dp_o, ack_p_o, ack_d_o, card_o, cards_dealt_o,
               deck_empty_o, busy_o, bad_card_o
    );

endinterface

// File: rtl/seed_random_2_rr_arb.sv
// -----------------------------------------------------------------------------
// seed_random_2_rr_arb
// Two-input round-robin arbiter. A lone requester always wins; on a tie the
// requester that was not granted last wins. The last-grant register resets to
// the dealer so the player wins the first tie.
//   clk_ctrl_i / rst_ctrl_i : clock, synchronous active-high reset
//   req_p / req_d           : player / dealer request levels
//   grant_en                : grant is actually taken this cycle
//   gnt_p / gnt_d           : one-hot (or zero) combinational grant
// -----------------------------------------------------------------------------
module seed_random_2_rr_arb (
    input  logic clk_ctrl_i,
    input  logic rst_ctrl_i,
    input  logic req_p,
    input  logic req_d,
    input  logic grant_en,
    output logic gnt_p,
    output logic gnt_d
);

    logic last_d_r;

    // Grant decision from the current requests and the last winner.
    always_comb begin
        gnt_p = 1'b0;
        gnt_d = 1'b0;
        if (req_p && req_d) begin
            if (last_d_r) begin
                gnt_p = 1'b1;
            end else begin
                gnt_d = 1'b1;
            end
        end else if (req_p) begin
            gnt_p = 1'b1;
        end else if (req_d) begin
            gnt_d = 1'b1;
        end else begin
            gnt_p = 1'b0;
            gnt_d = 1'b0;
        end
    end

    // Remember who won, only when the grant is consumed.
    always_ff @(posedge clk_ctrl_i) begin
        if (rst_ctrl_i) begin
            last_d_r <= 1'b1;
        end else if (grant_en && (gnt_p || gnt_d)) begin
            last_d_r <= gnt_d;
        end else begin
            last_d_r <= last_d_r;
        end
    end

endmodule

// File: rtl/seed_random_2_deal_ctrl.sv
// -----------------------------------------------------------------------------
// seed_random_2_deal_ctrl
// Deals cards from a datapath to a player and a dealer. One request is
// granted at a time (round-robin), the datapath is pulsed once, the card is
// captured CARD_LAT cycles later and delivered with a one-cycle ack.
//   clk_ctrl_i / rst_ctrl_i : clock, synchronous active-high reset
//   deal_if (slave)         : requests, new-deck pulse, datapath card in;
//                             acks, card, dealt count, deck/busy/bad flags out
// All outputs are registered; their next values are decoded from the next
// state so they line up with the state they describe.
// -----------------------------------------------------------------------------
module seed_random_2_deal_ctrl
    import seed_random_2_deal_ctrl_pkg::*;
#(
    parameter int CARD_LAT  = CARD_LAT_DEF,
    parameter int DECK_SIZE = DECK_SIZE_DEF
) (
    input logic                      clk_ctrl_i,
    input logic                      rst_ctrl_i,
    seed_random_2_deal_ctrl_if.slave deal_if
);

    localparam int CNT_W = (CARD_LAT < 1) ? 1 : $clog2(CARD_LAT + 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(CARD_LAT);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [DEALT_W-1:0] DECK_FULL = DEALT_W'(DECK_SIZE);

    deal_state_e        state_r, state_nxt_s;
    owner_e             owner_r, owner_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               pending_r, pending_nxt_s;
    logic [DEALT_W-1:0] cards_dealt_r, cards_dealt_nxt_s;
    logic [CARD_W-1:0]  card_r, card_nxt_s;
    logic               bad_r, bad_nxt_s;
    logic               deck_empty_r, deck_empty_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               req_card_r, req_card_nxt_s;
    logic               ack_p_r, ack_p_nxt_s;
    logic               ack_d_r, ack_d_nxt_s;

    logic any_req_s;
    logic clear_s;
    logic take_s;
    logic capture_s;
    logic gnt_p_s;
    logic gnt_d_s;

    seed_random_2_rr_arb u_arb (
        .clk_ctrl_i (clk_ctrl_i),
        .rst_ctrl_i (rst_ctrl_i),
        .req_p      (deal_if.req_p_i),
        .req_d      (deal_if.req_d_i),
        .grant_en   (take_s),
        .gnt_p      (gnt_p_s),
        .gnt_d      (gnt_d_s)
    );

    // IDLE decisions: a new deck (pending or live) is served before any grant.
    always_comb begin
        any_req_s = deal_if.req_p_i | deal_if.req_d_i;
        clear_s   = 1'b0;
        take_s    = 1'b0;
        if (state_r == ST_IDLE) begin
            clear_s = pending_r | deal_if.new_deck_i;
            take_s  = ~clear_s & ~deck_empty_r & any_req_s;
        end else begin
            clear_s = 1'b0;
            take_s  = 1'b0;
        end
        capture_s = (state_r == ST_WAIT) && (cnt_r <= CNT_ONE);
    end

    // State register.
    always_ff @(posedge clk_ctrl_i) begin
        if (rst_ctrl_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ:     state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (capture_s) begin
                    state_nxt_s = ST_DELIVER;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DELIVER: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the datapath registers and registered outputs.
    always_comb begin
        owner_nxt_s = owner_r;
        if (take_s && gnt_d_s) begin
            owner_nxt_s = OWN_D;
        end else if (take_s && gnt_p_s) begin
            owner_nxt_s = OWN_P;
        end else begin
            owner_nxt_s = owner_r;
        end

        cnt_nxt_s = cnt_r;
        case (state_r)
            ST_REQ:  cnt_nxt_s = CNT_LOAD;
            ST_WAIT: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            default: cnt_nxt_s = cnt_r;
        endcase

        // Pulses arriving mid-transaction collapse into one pending clear.
        pending_nxt_s = pending_r;
        if (clear_s) begin
            pending_nxt_s = 1'b0;
        end else if (deal_if.new_deck_i) begin
            pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s = pending_r;
        end

        // Count moves with the ack so both become visible in DELIVER.
        cards_dealt_nxt_s = cards_dealt_r;
        if (clear_s) begin
            cards_dealt_nxt_s = {DEALT_W{1'b0}};
        end else if (capture_s) begin
            cards_dealt_nxt_s = cards_dealt_r + 6'd1;
        end else begin
            cards_dealt_nxt_s = cards_dealt_r;
        end

        card_nxt_s = card_r;
        bad_nxt_s  = bad_r;
        if (capture_s) begin
            card_nxt_s = deal_if.card_dp_i;
            bad_nxt_s  = bad_r | is_bad_card(deal_if.card_dp_i);
        end else begin
            card_nxt_s = card_r;
            bad_nxt_s  = bad_r;
        end

        deck_empty_nxt_s = (cards_dealt_nxt_s == DECK_FULL);
        busy_nxt_s       = (state_nxt_s != ST_IDLE);
        req_card_nxt_s   = (state_nxt_s == ST_REQ);
        ack_p_nxt_s      = (state_nxt_s == ST_DELIVER) && (owner_nxt_s == OWN_P);
        ack_d_nxt_s      = (state_nxt_s == ST_DELIVER) && (owner_nxt_s == OWN_D);
    end

    // Datapath and output registers.
    always_ff @(posedge clk_ctrl_i) begin
        if (rst_ctrl_i) begin
            owner_r       <= OWN_P;
            cnt_r         <= {CNT_W{1'b0}};
            pending_r     <= 1'b0;
            cards_dealt_r <= {DEALT_W{1'b0}};
            card_r        <= 8'd0;
            bad_r         <= 1'b0;
            deck_empty_r  <= 1'b0;
            busy_r        <= 1'b0;
            req_card_r    <= 1'b0;
            ack_p_r       <= 1'b0;
            ack_d_r       <= 1'b0;
        end else begin
            owner_r       <= owner_nxt_s;
            cnt_r         <= cnt_nxt_s;
            pending_r     <= pending_nxt_s;
            cards_dealt_r <= cards_dealt_nxt_s;
            card_r        <= card_nxt_s;
            bad_r         <= bad_nxt_s;
            deck_empty_r  <= deck_empty_nxt_s;
            busy_r        <= busy_nxt_s;
            req_card_r    <= req_card_nxt_s;
            ack_p_r       <= ack_p_nxt_s;
            ack_d_r       <= ack_d_nxt_s;
        end
    end

    assign deal_if.req_card_dp_o = req_card_r;
    assign deal_if.ack_p_o       = ack_p_r;
    assign deal_if.ack_d_o       = ack_d_r;
    assign deal_if.card_o        = card_r;
    assign deal_if.cards_dealt_o = cards_dealt_r;
    assign deal_if.deck_empty_o  = deck_empty_r;
    assign deal_if.busy_o        = busy_r;
    assign deal_if.bad_card_o    = bad_r;

endmodule

// File: tb/tb_seed_random_2_deal_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seed_random_2_deal_ctrl
// Transaction-level bench for the deal controller. A small model tracks the
// dealt count, the last round-robin winner and the sticky bad-card flag; each
// transaction predicts the cycle-by-cycle handshake from the stated latency.
// -----------------------------------------------------------------------------
module tb_seed_random_2_deal_ctrl;

    localparam int CARD_LAT  = 2;
    localparam int DECK_SIZE = 52;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;

    // Model state
    int   m_count;
    logic m_last_d;
    logic m_bad;
    logic last_win_d;
    int   ack_cyc;

    seed_random_2_deal_ctrl_if dif ();

    seed_random_2_deal_ctrl #(
        .CARD_LAT  (CARD_LAT),
        .DECK_SIZE (DECK_SIZE)
    ) dut (
        .clk_ctrl_i (clk),
        .rst_ctrl_i (rst),
        .deal_if    (dif)
    );

    initial clk = 1'b0;
    // Free-running clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_last_d = 1'b1;
        m_bad    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dif.req_p_i = 1'b0; dif.req_d_i = 1'b0; dif.new_deck_i = 1'b0;
        dif.card_dp_i = 8'd0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
    endtask

    // One full request/ack transaction starting in an IDLE cycle.
    task automatic run_txn(input logic rp, input logic rd, input logic [7:0] cval,
                           input logic drop_mid, input logic nd_mid, input logic keep);
        logic       win_d;
        logic [3:0] obs;
        logic [3:0] exp;
        if (rp && rd) win_d = !m_last_d;
        else          win_d = rd;
        m_last_d = win_d;
        dif.req_p_i = rp; dif.req_d_i = rd;
        tick();
        obs = {dif.req_card_dp_o, dif.ack_p_o, dif.ack_d_o, dif.busy_o};
        checks++;
        if (obs !== 4'b1001) begin
            failures++;
            $display("FAIL txn_req_cycle got=%b exp=%b cyc=%0d", obs, 4'b1001, cyc);
        end
        dif.card_dp_i = cval;
        if (drop_mid) begin
            dif.req_p_i = 1'b0; dif.req_d_i = 1'b0;
        end
        for (int k = 1; k <= CARD_LAT; k++) begin
            tick();
            dif.new_deck_i = nd_mid && (k == 1);
            obs = {dif.req_card_dp_o, dif.ack_p_o, dif.ack_d_o, dif.busy_o};
            checks++;
            if (obs !== 4'b0001) begin
                failures++;
                $display("FAIL txn_wait_cycle got=%b exp=%b cyc=%0d", obs, 4'b0001, cyc);
            end
        end
        tick();
        dif.new_deck_i = 1'b0;
        ack_cyc = cyc;
        m_count++;
        m_bad = m_bad | (cval == 8'd0);
        exp = {1'b0, ~win_d, win_d, 1'b1};
        obs = {dif.req_card_dp_o, dif.ack_p_o, dif.ack_d_o, dif.busy_o};
        last_win_d = dif.ack_d_o;
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL txn_ack got=%b exp=%b cyc=%0d", obs, exp, cyc);
        end
        checks++;
        if (dif.card_o !== cval) begin
            failures++;
            $display("FAIL txn_card got=%0d exp=%0d", dif.card_o, cval);
        end
        checks++;
        if ({dif.cards_dealt_o, dif.bad_card_o, dif.deck_empty_o} !==
            {6'(m_count), m_bad, (m_count == DECK_SIZE)}) begin
            failures++;
            $display("FAIL txn_count got=%0d/%b/%b exp=%0d/%b/%b", dif.cards_dealt_o,
                     dif.bad_card_o, dif.deck_empty_o, m_count, m_bad, (m_count == DECK_SIZE));
        end
        if (!keep) begin
            dif.req_p_i = 1'b0; dif.req_d_i = 1'b0;
        end
        tick();
        obs = {dif.req_card_dp_o, dif.ack_p_o, dif.ack_d_o, dif.busy_o};
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL txn_idle got=%b exp=%b cyc=%0d", obs, 4'b0000, cyc);
        end
        if (nd_mid) begin
            checks++;
            if (dif.cards_dealt_o !== 6'(m_count)) begin
                failures++;
                $display("FAIL nd_before_clear got=%0d exp=%0d", dif.cards_dealt_o, m_count);
            end
            tick();
            m_count = 0;
            checks++;
            if ({dif.cards_dealt_o, dif.busy_o, dif.deck_empty_o} !== 8'd0) begin
                failures++;
                $display("FAIL nd_clear got=%0d/%b/%b exp=0/0/0", dif.cards_dealt_o,
                         dif.busy_o, dif.deck_empty_o);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dif.req_p_i = 1'b1; dif.req_d_i = 1'b1; dif.new_deck_i = 1'b0;
        dif.card_dp_i = 8'd9;
        tick(); tick();
        checks++;
        if ({dif.req_card_dp_o, dif.ack_p_o, dif.ack_d_o, dif.busy_o, dif.deck_empty_o,
             dif.bad_card_o, dif.card_o, dif.cards_dealt_o} !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs got card=%0d dealt=%0d busy=%b", dif.card_o,
                     dif.cards_dealt_o, dif.busy_o);
        end
        do_reset();
    endtask

    task automatic test_first_deal();
        do_reset();
        run_txn(1'b1, 1'b0, 8'd17, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 8'(10 + i), 1'b0, 1'b0, 1'b1);
            checks++;
            if (last_win_d !== 1'(i % 2)) begin
                failures++;
                $display("FAIL rr_alternate i=%0d got_dealer=%b exp_dealer=%b", i, last_win_d, 1'(i % 2));
            end
        end
        dif.req_p_i = 1'b0; dif.req_d_i = 1'b0;
    endtask

    task automatic test_bad_card();
        do_reset();
        run_txn(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b1, 8'd52, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic rp, rd;
        logic [7:0] c;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            rp = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (!rp && !rd) rp = 1'b1;
            c = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 52));
            run_txn(rp, rd, c, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
    endtask

    task automatic test_deck_empty();
        logic rp, rd;
        int   clear_cyc;
        do_reset();
        for (int i = 0; i < DECK_SIZE; i++) begin
            rp = 1'($urandom_range(0, 1));
            rd = !rp | 1'($urandom_range(0, 1));
            run_txn(rp, rd, 8'($urandom_range(1, 52)), 1'b0, 1'b0, 1'b0);
        end
        dif.req_d_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({dif.req_card_dp_o, dif.ack_p_o, dif.ack_d_o, dif.busy_o, dif.deck_empty_o,
                 dif.cards_dealt_o} !== {5'b00001, 6'd52}) begin
                failures++;
                $display("FAIL empty_ignore got=%b%b%b%b%b dealt=%0d cyc=%0d", dif.req_card_dp_o,
                         dif.ack_p_o, dif.ack_d_o, dif.busy_o, dif.deck_empty_o, dif.cards_dealt_o, cyc);
            end
        end
        dif.new_deck_i = 1'b1;
        tick();
        dif.new_deck_i = 1'b0;
        clear_cyc = cyc;
        m_count = 0;
        checks++;
        if ({dif.cards_dealt_o, dif.busy_o, dif.req_card_dp_o, dif.deck_empty_o} !== 9'd0) begin
            failures++;
            $display("FAIL new_deck_clear got dealt=%0d busy=%b empty=%b", dif.cards_dealt_o,
                     dif.busy_o, dif.deck_empty_o);
        end
        run_txn(1'b0, 1'b1, 8'd44, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ack_cyc - clear_cyc !== 4) begin
            failures++;
            $display("FAIL new_deck_ack_latency got=%0d exp=4", ack_cyc - clear_cyc);
        end
    endtask

    task automatic test_new_deck_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b0, 8'(20 + i), 1'b0, 1'b0, 1'b0);
        end
        run_txn(1'b0, 1'b1, 8'd30, 1'b0, 1'b1, 1'b0);
        run_txn(1'b1, 1'b0, 8'd31, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_txn(1'b1, 1'b0, 8'd21, 1'b0, 1'b0, 1'b0);
        dif.req_p_i = 1'b1;
        tick();
        dif.card_dp_i = 8'd33;
        tick();
        rst = 1'b1;
        dif.req_p_i = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({dif.req_card_dp_o, dif.ack_p_o, dif.ack_d_o, dif.busy_o, dif.cards_dealt_o,
                 dif.card_o} !== 18'd0) begin
                failures++;
                $display("FAIL reset_mid got dealt=%0d card=%0d ack=%b%b busy=%b", dif.cards_dealt_o,
                         dif.card_o, dif.ack_p_o, dif.ack_d_o, dif.busy_o);
            end
        end
        run_txn(1'b1, 1'b1, 8'd40, 1'b0, 1'b0, 1'b0);
        checks++;
        if (last_win_d !== 1'b0) begin
            failures++;
            $display("FAIL reset_tie_player got_dealer=%b exp_dealer=0", last_win_d);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        ack_cyc  = 0;
        last_win_d = 1'b0;
        model_reset();
        test_reset();
        test_first_deal();
        test_back_to_back();
        test_bad_card();
        test_random();
        test_deck_empty();
        test_new_deck_mid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seed_random_2_deal_ctrl.md
SEED_RANDOM_2_DEAL_CTRL -- requirements
Module: seed_random_2_deal_ctrl

Interface
REQ-001 Parameter CARD_LAT, default 2: cycles from req_card_dp_o high to a valid card_dp_i (counter plus registered selector).
REQ-002 Parameter DECK_SIZE, default 52: cards dealt before the deck is exhausted.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk_ctrl_i in 1, rising-edge clock; rst_ctrl_i in 1, synchronous active-high reset.
REQ-004 req_p_i in 1: player card request, level, held until ack_p_o.
REQ-005 req_d_i in 1: dealer card request, level, held until ack_d_o.
REQ-006 new_deck_i in 1: single-cycle pulse that restarts the dealt count.
REQ-007 card_dp_i in 8: card value from the datapath; 1..52 valid, 0 invalid.
REQ-008 req_card_dp_o out 1: single-cycle pulse that advances the datapath.
REQ-009 ack_p_o / ack_d_o out 1 each: single-cycle delivery strobe to the player / dealer.
REQ-010 card_o out 8: last delivered card, registered and held until the next delivery.
REQ-011 cards_dealt_o out 6: number of cards delivered since reset or new deck.
REQ-012 deck_empty_o out 1: high while cards_dealt_o == DECK_SIZE.
REQ-013 busy_o out 1: high in every state except IDLE.
REQ-014 bad_card_o out 1: sticky flag, set when a delivered card is 0.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and DELIVER.
REQ-016 IDLE, no pending new deck, !deck_empty_o, any request: grant one requester, latch it as owner and go to REQ; otherwise stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: a lone requester wins; on a tie the requester not granted last wins; the player wins the first tie after reset.
REQ-018 REQ: req_card_dp_o = 1 for exactly one cycle, wait counter loaded with CARD_LAT, next state WAIT.
REQ-019 WAIT: the counter decrements each cycle; at the edge where it reaches 0, card_dp_i is captured into card_o and the FSM goes to DELIVER.
REQ-020 DELIVER: the owner's ack is high for one cycle, cards_dealt_o increments, and the FSM returns to IDLE.
REQ-021 Latency: with req seen in IDLE at cycle n, req_card_dp_o is high at n+1 and the ack at n+2+CARD_LAT (n+4 at the default).
REQ-022 A requester SHALL drop its req on the edge after its ack; a req still high in the following IDLE cycle SHALL count as a new request.
REQ-023 At cards_dealt_o == DECK_SIZE, requests SHALL be ignored, with no ack and no req_card_dp_o, until a new deck.
REQ-024 new_deck_i in IDLE clears cards_dealt_o next cycle and takes priority over a simultaneous request, which is granted one cycle later.
REQ-025 new_deck_i outside IDLE SHALL set a pending flag; the clear happens on the first IDLE cycle, before arbitration; repeated pulses collapse into one.
REQ-026 A request dropped by its owner mid-transaction SHALL not abort it; the card is still delivered and counted.
REQ-027 A captured card of 0 SHALL be delivered and counted and SHALL set bad_card_o.
REQ-028 ack_p_o and ack_d_o SHALL never be high together, and either ack implies busy_o.

Reset
REQ-029 While rst_ctrl_i is high at a clock edge: state = IDLE, all outputs = 0, last-grant = dealer, pending flag and wait counter cleared.
REQ-030 Reset mid-transaction SHALL abandon it: no ack, card not counted.
REQ-031 The datapath reset is owned by the top level, not by this block.

Structure
REQ-032 State encodings and the DECK_SIZE / CARD_LAT defaults SHALL live in the shared seed_random_2 header.
REQ-033 One sub-module, seed_random_2_rr_arb, SHALL hold the two-input round-robin grant and last-grant register; everything else is in the top module.

Verification
REQ-034 Player req at cycle 10, card_dp_i = 17 at cycle 13 -> req_card_dp_o high at cycle 11, ack_p_o high at cycle 14, card_o = 17, cards_dealt_o = 1.
REQ-035 Both requests held continuously for 4 deliveries -> acks alternate P, D, P, D; never both high; busy_o low one cycle between deliveries.
REQ-036 52 deliveries, then req_d_i high -> deck_empty_o = 1, no req_card_dp_o for 20 cycles; new_deck_i -> cards_dealt_o = 0, dealer acked 4 cycles after the clear cycle.
REQ-037 new_deck_i during WAIT of the 5th card -> card delivered with cards_dealt_o = 5, then cleared to 0 in the next IDLE cycle.
REQ-038 rst_ctrl_i high during WAIT -> no ack, cards_dealt_o = 0, card_o = 0; next request grants the player on a tie.
REQ-039 card_dp_i = 0 at capture -> ack issued, bad_card_o = 1, stays 1 until reset.
